stopwatch_display: RTL



---
 rtl/stopwatch_display_if.sv | 25 ++
 rtl/stopwatch_display.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_if.sv
// Signal bundle between a stopwatch time source and the MM:SS 7-segment display driver.
interface stopwatch_display_if;
    logic [7:0]  minutes;
    logic [5:0]  seconds;
    logic [1:0]  status;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] bcd;
    logic        busy;
    logic        ovf;
    logic [1:0]  state_dbg;

    // No handshake: the source presents levels continuously and the display samples
    // them whenever its converter is idle; busy only reports that a conversion is running.
    modport master (
        output minutes, seconds, status,
        input  an, seg, dp, bcd, busy, ovf, state_dbg
    );

    modport slave (
        input  minutes, seconds, status,
        output an, seg, dp, bcd, busy, ovf, state_dbg
    );
endinterface

// File: rtl/stopwatch_display.sv
// Binary MM:SS to BCD (sequential double-dabble) plus a 4-digit multiplexed common-anode display.
// Optional macro STOPWATCH_DISP_BLINK_EN blanks the display on alternating periods while paused.
module stopwatch_display #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_display_if.slave  dif
);

    localparam int              PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MIN    = 2'd1,
        S_SEC    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] last_q, last_d;
    logic [7:0]  work_q, work_d;
    logic [6:0]  bin_q, bin_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  min_bcd_q, min_bcd_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [15:0] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [14:0] shifted;
    logic [6:0]  min_clamped;
    logic        scan_step;
    logic [3:0]  nibble;
    logic        blank;

    function automatic logic [7:0] add3(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (v[7:4] >= 4'd5) ? v[7:4] + 4'd3 : v[7:4];
        lo = (v[3:0] >= 4'd5) ? v[3:0] + 4'd3 : v[3:0];
        return {hi, lo};
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign min_clamped = (dif.minutes > 8'd99) ? 7'd99 : dif.minutes[6:0];
    // One double-dabble step: correct digits >= 5, then shift the next binary MSB in.
    assign shifted     = {add3(work_q), bin_q} << 1;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        work_d     = work_q;
        bin_d      = bin_q;
        iter_d     = iter_q;
        min_bcd_d  = min_bcd_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if ({dif.minutes, dif.seconds} != last_q) begin
                    last_d     = {dif.minutes, dif.seconds};
                    bin_d      = min_clamped;
                    work_d     = 8'h00;
                    iter_d     = 3'd0;
                    ovf_pend_d = (dif.minutes > 8'd99);
                    state_d    = S_MIN;
                end
            end
            S_MIN: begin
                work_d = shifted[14:7];
                bin_d  = shifted[6:0];
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd6) begin
                    // Seconds come from the captured copy so mid-conversion input changes are ignored.
                    min_bcd_d = shifted[14:7];
                    work_d    = 8'h00;
                    bin_d     = {last_q[5:0], 1'b0};
                    iter_d    = 3'd0;
                    state_d   = S_SEC;
                end
            end
            S_SEC: begin
                work_d = shifted[14:7];
                bin_d  = shifted[6:0];
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd5) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                bcd_d   = {min_bcd_q, work_q};
                ovf_d   = ovf_pend_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign scan_step = (presc_q == PRESC_MAX);

    always_comb begin
        case (idx_q)
            2'd0:    nibble = bcd_q[3:0];
            2'd1:    nibble = bcd_q[7:4];
            2'd2:    nibble = bcd_q[11:8];
            default: nibble = bcd_q[15:12];
        endcase
    end

`ifdef STOPWATCH_DISP_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (dif.status != 2'b10) begin
            frame_d = '0;
            phase_d = 1'b0;
        end else if (scan_step && idx_q == 2'd3) begin
            if (frame_q == FRAME_MAX) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign blank = (dif.status == 2'b10) && phase_q;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        presc_d = scan_step ? '0 : presc_q + 1'b1;
        idx_d   = scan_step ? idx_q + 2'd1 : idx_q;
        an_d    = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d   = enc(nibble);
        // The colon is the minutes-units decimal point, lit only while the clock is live.
        dp_d    = ~((idx_q == 2'd2) && (dif.status == 2'b01 || dif.status == 2'b10));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= '0;
            work_q     <= '0;
            bin_q      <= '0;
            iter_q     <= '0;
            min_bcd_q  <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            an_q       <= 4'b1111;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            work_q     <= work_d;
            bin_q      <= bin_d;
            iter_q     <= iter_d;
            min_bcd_q  <= min_bcd_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign dif.an        = an_q;
    assign dif.seg       = seg_q;
    assign dif.dp        = dp_q;
    assign dif.bcd       = bcd_q;
    assign dif.ovf       = ovf_q;
    assign dif.busy      = (state_q != S_IDLE);
    assign dif.state_dbg = state_q;

endmodule
